// File: rtl/alu_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_ctrl_pkg
//  Purpose  : Shared constants for the ALU issue stage: R-type funct codes,
//             ALU Operation encodings and issue FSM state encodings.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_issue_ctrl_pkg;

    // R-type funct codes understood by the issue stage
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;

    // ALU Operation select encodings
    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;

    // Issue FSM states
    localparam int         ST_W    = 2;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/alu_issue_ctrl_funct_decode.sv
`default_nettype none
// ============================================================================
//  Module   : alu_funct_decode
//  Purpose  : Combinational decode of an R-type funct field into ALU control
//             (Operation, Binvert, Carryin) plus arithmetic / illegal flags.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_funct_decode
    import alu_issue_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [1:0] operation,
    output logic       binvert,
    output logic       carryin,
    output logic       is_arith,
    output logic       err
);

    // Map funct to ALU control; unknown codes drive a harmless AND and flag err
    always_comb begin
        operation = OP_AND;
        binvert   = 1'b0;
        carryin   = 1'b0;
        is_arith  = 1'b0;
        err       = 1'b0;
        case (funct)
            FUNCT_AND: operation = OP_AND;
            FUNCT_OR:  operation = OP_OR;
            FUNCT_ADD: begin
                operation = OP_ADD;
                is_arith  = 1'b1;
            end
            FUNCT_SUB: begin
                // a - b computed as a + ~b + 1
                operation = OP_ADD;
                binvert   = 1'b1;
                carryin   = 1'b1;
                is_arith  = 1'b1;
            end
            default:   err = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_ctrl
//  Purpose  : Issue stage in front of a 32-bit combinational ALU. Accepts one
//             R-type op per handshake, drives the ALU from registers, captures
//             the result with carry/zero/overflow/error flags and holds it for
//             a downstream valid/ready consumer.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    // request side
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_funct,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    // ALU side
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_binvert,
    output logic             alu_carryin,
    output logic [1:0]       alu_operation,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carryout,
    // result side
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_ovf,
    output logic             out_err,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [ST_W-1:0]  r_state;
    logic [ST_W-1:0]  w_next_state;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_accept;
    logic             w_consume;

    logic [1:0]       w_dec_op;
    logic             w_dec_binv;
    logic             w_dec_cin;
    logic             w_dec_arith;
    logic             w_dec_err;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_op;
    logic             r_binv;
    logic             r_cin;
    logic             r_arith;
    logic             r_err;

    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_zero;
    logic             r_ovf;
    logic             r_out_err;
    logic [CNT_W-1:0] r_count;

    logic [WIDTH-1:0] w_bi;
    logic [WIDTH-1:0] w_cap_result;
    logic             w_cap_ovf;

    alu_funct_decode u_decode (
        .funct     (in_funct),
        .operation (w_dec_op),
        .binvert   (w_dec_binv),
        .carryin   (w_dec_cin),
        .is_arith  (w_dec_arith),
        .err       (w_dec_err)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state: EXEC always lasts one cycle; DONE leaves only when consumed
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (in_valid) w_next_state = ST_EXEC;
            ST_EXEC: w_next_state = ST_DONE;
            ST_DONE: if (out_ready) w_next_state = in_valid ? ST_EXEC : ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Handshake outputs: DONE can take a new request in the cycle it is drained
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            ST_IDLE: w_in_ready = 1'b1;
            ST_DONE: begin
                w_in_ready  = out_ready;
                w_out_valid = 1'b1;
            end
            default: begin
                w_in_ready  = 1'b0;
                w_out_valid = 1'b0;
            end
        endcase
    end

    assign w_accept  = in_valid & w_in_ready;
    assign w_consume = w_out_valid & out_ready;

    // Latch operands and decoded control so the ALU never sees in_* directly
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= OP_AND;
            r_binv  <= 1'b0;
            r_cin   <= 1'b0;
            r_arith <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_op    <= w_dec_op;
            r_binv  <= w_dec_binv;
            r_cin   <= w_dec_cin;
            r_arith <= w_dec_arith;
            r_err   <= w_dec_err;
        end
    end

    // Overflow uses the effective second operand as seen by the adder
    assign w_bi         = r_binv ? ~r_b : r_b;
    assign w_cap_result = r_err ? '0 : alu_result;
    assign w_cap_ovf    = r_arith & (r_a[WIDTH-1] == w_bi[WIDTH-1])
                                  & (alu_result[WIDTH-1] != r_a[WIDTH-1]);

    // Capture ALU result and flags at the end of EXEC; hold through DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result  <= '0;
            r_carry   <= 1'b0;
            r_zero    <= 1'b0;
            r_ovf     <= 1'b0;
            r_out_err <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            r_result  <= w_cap_result;
            r_carry   <= r_arith & alu_carryout;
            r_zero    <= (w_cap_result == '0);
            r_ovf     <= w_cap_ovf;
            r_out_err <= r_err;
        end
    end

    // Completed-operation counter, free-running wrap
    always_ff @(posedge clk) begin
        if (reset)          r_count <= '0;
        else if (w_consume) r_count <= r_count + C_CNT_ONE;
    end

    assign in_ready      = w_in_ready;
    assign out_valid     = w_out_valid;
    assign alu_a         = r_a;
    assign alu_b         = r_b;
    assign alu_binvert   = r_binv;
    assign alu_carryin   = r_cin;
    assign alu_operation = r_op;
    assign out_result    = r_result;
    assign out_carry     = r_carry;
    assign out_zero      = r_zero;
    assign out_ovf       = r_ovf;
    assign out_err       = r_out_err;
    assign op_count      = r_count;

endmodule
`default_nettype wire

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Sequencing stage that sits directly upstream of the 32-bit ALU (AND/OR/ADD/SUB, Binvert/Carryin/Operation control).
- Accepts one R-type operation per valid/ready handshake and decodes its funct field into ALU control.
- Drives the ALU from registered operands, then captures the ALU's combinational result with derived flags into an output register.
- Presents the captured result downstream with valid/ready backpressure.

Parameters:
WIDTH, 32, datapath width; must equal ALU width (32).
CNT_W, 16, width of completed-operation counter.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  request present.
in_ready  output  1  stage can accept request this cycle.
in_funct  input  6  operation code.
in_a  input  WIDTH  operand A.
in_b  input  WIDTH  operand B.
alu_a  output  WIDTH  to ALU a.
alu_b  output  WIDTH  to ALU b.
alu_binvert  output  1  to ALU Binvert.
alu_carryin  output  1  to ALU Carryin.
alu_operation  output  2  to ALU Operation.
alu_result  input  WIDTH  from ALU Result (combinational).
alu_carryout  input  1  from ALU CarryOut.
out_valid  output  1  result held.
out_ready  input  1  consumer takes result.
out_result  output  WIDTH  captured result.
out_carry  output  1  carry (ADD/SUB only, else 0).
out_zero  output  1  out_result == 0.
out_ovf  output  1  signed overflow (ADD/SUB only, else 0).
out_err  output  1  illegal funct.
op_count  output  CNT_W  completed handshakes, wraps.

Behaviour:
- Funct decode:
  - 100100 AND: op 00, binv 0, cin 0.
  - 100101 OR: op 01, binv 0, cin 0.
  - 100000 ADD: op 10, binv 0, cin 0.
  - 100010 SUB: op 10, binv 1, cin 1.
  - Any other code is illegal: op 00, binv 0, cin 0, err 1.
- ALU control outputs and alu_a/alu_b come from internal registers only; they never come combinationally from in_*.
- FSM states IDLE, EXEC, DONE. Reset state is IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid, latch in_a, in_b and the decoded control, then go to EXEC.
- EXEC (exactly 1 cycle):
  - in_ready = 0.
  - At the clock edge, capture the result fields and go to DONE:
    - out_result = alu_result (forced 0 if err).
    - out_carry = alu_carryout for ADD/SUB.
    - out_zero from the captured result.
    - out_ovf = (alu_a[W-1] == bi[W-1]) & (alu_result[W-1] != alu_a[W-1]), where bi = binv ? ~alu_b : alu_b; ADD/SUB only.
    - out_err as decoded.
- DONE:
  - out_valid = 1.
  - All out_* stay stable while out_ready = 0.
  - in_ready = out_ready.
  - On out_ready & in_valid: op_count++, latch the new request, go to EXEC (back-to-back; throughput 1 op per 2 cycles).
  - On out_ready & !in_valid: op_count++, go to IDLE.
- Latency: accept edge to out_valid high = 2 cycles.
- in_valid while in_ready = 0 is ignored; the upstream producer holds the request.
- op_count wraps from 2^CNT_W-1 to 0 with no saturation.
- Reset (any state, including mid-EXEC or DONE):
  - Discards any in-flight op.
  - Next cycle: state IDLE, out_valid 0, in_ready 1.
  - out_result 0, out_carry/out_zero/out_ovf/out_err 0, op_count 0.
  - alu_a/alu_b 0, alu_operation 00, alu_binvert 0, alu_carryin 0.

Decomposition:
- Shared package/header holds:
  - funct constants FUNCT_ADD/SUB/AND/OR.
  - ALU operation encodings OP_AND=00, OP_OR=01, OP_ADD=10.
  - FSM state encodings.
- One sub-module, alu_funct_decode (combinational): funct → {operation, binvert, carryin, is_arith, err}.
- FSM, registers and flag logic live in alu_issue_ctrl.
- The bench instantiates the existing ALU wired to the alu_* ports.

Test Plan:
- Reset, then issue AND, OR, ADD in sequence, each with a=A5A5A5A5, b=5A5A5A5A and out_ready=1:
  - AND → result 00000000, zero 1.
  - OR → FFFFFFFF.
  - ADD → FFFFFFFF, carry 0, ovf 0.
  - Each out_valid asserts 2 cycles after accept.
- SUB a=A5A5A5A5, b=5A5A5A5A → 4B4B4B4B, carry 1, ovf 1. ADD 7FFFFFFF+00000001 → 80000000, ovf 1, carry 0.
- funct=000000 with a=FFFFFFFF, b=FFFFFFFF → err 1, result 00000000, zero 1, carry 0, ovf 0.
- Backpressure: out_ready=0 for 5 cycles after out_valid:
  - out_* stable and in_ready=0 throughout.
  - On release, op_count increments by exactly 1.
- Back-to-back: in_valid=1 and out_ready=1 continuously for 8 ops → out_valid pulses every 2nd cycle, results in order, op_count=8.
- Assert reset during EXEC and again during DONE:
  - Next cycle all outputs take their reset values and in_ready=1.
  - No result for the aborted op ever appears.
